// File: rtl/gshare_predictor_if.sv
// Fetch-side bundle for the gshare predictor: IF lookup, pipeline control,
// EX resolution, and the prediction/statistics returned to the fetch stage.
interface gshare_predictor_if;
    logic        lookup_valid;
    logic [31:0] lookup_pc;
    logic        hold;
    logic        flush;
    logic        update_valid;
    logic        update_taken;
    logic        prediction;
    logic        mispredict;
    logic        update_orphan;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;

    modport master (
        output lookup_valid, lookup_pc, hold, flush, update_valid, update_taken,
        input  prediction, mispredict, update_orphan, branch_count, mispredict_count
    );

    modport slave (
        input  lookup_valid, lookup_pc, hold, flush, update_valid, update_taken,
        output prediction, mispredict, update_orphan, branch_count, mispredict_count
    );
endinterface

// File: rtl/gshare_predictor.sv
// Gshare branch direction predictor. A table of 2-bit saturating counters
// is indexed by PC ^ global history in IF. The index and predicted direction
// ride a two-slot shadow pipeline (ID, EX) so that the resolving branch in EX
// trains exactly the counter it was predicted from. History is updated only
// by resolved branches, so it is non-speculative.
module gshare_predictor #(
    parameter int GHR_BITS = 8
) (
    input logic             clk,
    input logic             reset,
    gshare_predictor_if.slave bus
);
    localparam int ENTRIES = 1 << GHR_BITS;

    typedef logic [GHR_BITS-1:0] idx_t;

    typedef struct packed {
        logic valid;
        idx_t idx;
        logic pred;
    } slot_t;

    logic [1:0]  pht [ENTRIES];
    idx_t        ghr;
    slot_t       slot_id;
    slot_t       slot_ex;
    logic        orphan;
    logic [31:0] branch_cnt;
    logic [31:0] mispredict_cnt;

    idx_t        lookup_idx;
    logic        pred;
    logic        train;
    logic        mispred;
    logic [1:0]  ctr_cur;
    logic [1:0]  ctr_next;

    // PC bits outside the index field do not affect the prediction.
    logic unused_pc;
    assign unused_pc = ^{bus.lookup_pc[31:GHR_BITS+2], bus.lookup_pc[1:0]};

    // Lookup path, EX resolution, and the saturating next value of the EX counter.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        lookup_idx = bus.lookup_pc[GHR_BITS+1:2] ^ ghr;
        pred       = bus.lookup_valid & pht[lookup_idx][1];
        train      = bus.update_valid & slot_ex.valid;
        mispred    = train & (bus.update_taken != slot_ex.pred);
        ctr_cur    = pht[slot_ex.idx];
        ctr_next   = ctr_cur;
        if (bus.update_taken) begin
            if (ctr_cur != 2'b11) ctr_next = ctr_cur + 2'd1;
        end else begin
            if (ctr_cur != 2'b00) ctr_next = ctr_cur - 2'd1;
        end
    end

    // Table, history, shadow slots and statistics; reset wins over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the counter table is reset explicitly because every entry must start weakly not-taken.
            for (int i = 0; i < ENTRIES; i++) pht[i] <= 2'b01;
            ghr            <= '0;
            slot_id        <= '0;
            slot_ex        <= '0;
            orphan         <= 1'b0;
            branch_cnt     <= '0;
            mispredict_cnt <= '0;
        end else begin
            // NOTE: non-blocking assignments, so the lookup above reads the pre-update counter.
            if (train) begin
                pht[slot_ex.idx] <= ctr_next;
                ghr              <= idx_t'({ghr, bus.update_taken});
                branch_cnt       <= branch_cnt + 32'd1;
                if (mispred) mispredict_cnt <= mispredict_cnt + 32'd1;
            end else if (bus.update_valid) begin
                orphan <= 1'b1;
            end

            if (bus.flush) begin
                slot_id <= '0;
                slot_ex <= '0;
            end else if (!bus.hold) begin
                slot_ex <= slot_id;
                slot_id <= '{valid: bus.lookup_valid, idx: lookup_idx, pred: pred};
            end
        end
    end

    assign bus.prediction       = pred;
    assign bus.mispredict       = mispred;
    assign bus.update_orphan    = orphan;
    assign bus.branch_count     = branch_cnt;
    assign bus.mispredict_count = mispredict_cnt;
endmodule
